// File: rtl/regbus_arbiter_if.sv
// Request/acknowledge bundle between the two requesters, the arbiter and the register bank.
// The arbiter takes the slave view. The master view is the mirror image.
interface regbus_arbiter_if #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DATA_W = 8
);

  logic              a_req;
  logic              a_we;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata;
  logic              a_ack;
  logic [DATA_W-1:0] a_rdata;

  logic              b_req;
  logic              b_we;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_wdata;
  logic              b_ack;
  logic [DATA_W-1:0] b_rdata;

  logic              reg_read;
  logic              reg_write;
  logic [ADDR_W-1:0] reg_addr;
  logic [DATA_W-1:0] reg_wdata;
  logic [DATA_W-1:0] reg_rdata;

  modport slave (
    input  a_req, a_we, a_addr, a_wdata,
    input  b_req, b_we, b_addr, b_wdata,
    input  reg_rdata,
    output a_ack, a_rdata, b_ack, b_rdata,
    output reg_read, reg_write, reg_addr, reg_wdata
  );

  modport master (
    output a_req, a_we, a_addr, a_wdata,
    output b_req, b_we, b_addr, b_wdata,
    output reg_rdata,
    input  a_ack, a_rdata, b_ack, b_rdata,
    input  reg_read, reg_write, reg_addr, reg_wdata
  );

endinterface

// File: rtl/regbus_arbiter.sv
// Two-port round-robin arbiter in front of the single register-bank access port.
// One transaction is in flight at a time. All outputs are registered.
module regbus_arbiter #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  regbus_arbiter_if.slave   bus,
  output logic              busy,
  output logic              last_grant
);

  localparam int unsigned CNT_W = 3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  typedef struct packed {
    logic              port;   // 0=A, 1=B
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } xact_t;

  state_t            r_state,      w_state_nxt;
  logic [CNT_W-1:0]  r_cnt,        w_cnt_nxt;
  xact_t             r_xact,       w_xact_nxt;
  logic              r_reg_read,   w_reg_read_nxt;
  logic              r_reg_write,  w_reg_write_nxt;
  logic              r_a_ack,      w_a_ack_nxt;
  logic              r_b_ack,      w_b_ack_nxt;
  logic [DATA_W-1:0] r_a_rdata,    w_a_rdata_nxt;
  logic [DATA_W-1:0] r_b_rdata,    w_b_rdata_nxt;
  logic              r_busy,       w_busy_nxt;
  logic              r_last_grant, w_last_grant_nxt;
  logic              w_pick_b;

  // B wins when it is the only requester, or on a tie when A completed last.
  assign w_pick_b = bus.b_req && (!bus.a_req || !r_last_grant);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_xact       <= '0;
      r_reg_read   <= 1'b0;
      r_reg_write  <= 1'b0;
      r_a_ack      <= 1'b0;
      r_b_ack      <= 1'b0;
      r_a_rdata    <= '0;
      r_b_rdata    <= '0;
      r_busy       <= 1'b0;
      r_last_grant <= 1'b1;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_xact       <= w_xact_nxt;
      r_reg_read   <= w_reg_read_nxt;
      r_reg_write  <= w_reg_write_nxt;
      r_a_ack      <= w_a_ack_nxt;
      r_b_ack      <= w_b_ack_nxt;
      r_a_rdata    <= w_a_rdata_nxt;
      r_b_rdata    <= w_b_rdata_nxt;
      r_busy       <= w_busy_nxt;
      r_last_grant <= w_last_grant_nxt;
    end
  end

  // Next-state and next-output logic. Every registered output is computed one cycle early.
  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_xact_nxt       = r_xact;
    w_reg_read_nxt   = 1'b0;
    w_reg_write_nxt  = 1'b0;
    w_a_ack_nxt      = 1'b0;
    w_b_ack_nxt      = 1'b0;
    w_a_rdata_nxt    = r_a_rdata;
    w_b_rdata_nxt    = r_b_rdata;
    w_last_grant_nxt = r_last_grant;

    unique case (r_state)
      S_IDLE: begin
        if (bus.a_req || bus.b_req) begin
          if (w_pick_b) begin
            w_xact_nxt.port  = 1'b1;
            w_xact_nxt.we    = bus.b_we;
            w_xact_nxt.addr  = bus.b_addr;
            w_xact_nxt.wdata = bus.b_wdata;
          end else begin
            w_xact_nxt.port  = 1'b0;
            w_xact_nxt.we    = bus.a_we;
            w_xact_nxt.addr  = bus.a_addr;
            w_xact_nxt.wdata = bus.a_wdata;
          end
          w_reg_write_nxt = w_xact_nxt.we;
          w_reg_read_nxt  = !w_xact_nxt.we;
          w_state_nxt     = S_ISSUE;
        end
      end

      S_ISSUE: begin
        if (r_xact.we) begin
          w_a_ack_nxt      = !r_xact.port;
          w_b_ack_nxt      = r_xact.port;
          w_last_grant_nxt = r_xact.port;
          w_state_nxt      = S_DONE;
        end else begin
          w_cnt_nxt   = CNT_W'(RD_LAT);
          w_state_nxt = S_WAIT;
        end
      end

      // The last WAIT cycle is RD_LAT cycles after ISSUE, so reg_rdata is valid here.
      S_WAIT: begin
        if (r_cnt == CNT_W'(1)) begin
          if (r_xact.port) begin
            w_b_rdata_nxt = bus.reg_rdata;
          end else begin
            w_a_rdata_nxt = bus.reg_rdata;
          end
          w_a_ack_nxt      = !r_xact.port;
          w_b_ack_nxt      = r_xact.port;
          w_last_grant_nxt = r_xact.port;
          w_state_nxt      = S_DONE;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end

      S_DONE: begin
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  assign bus.reg_read  = r_reg_read;
  assign bus.reg_write = r_reg_write;
  assign bus.reg_addr  = r_xact.addr;
  assign bus.reg_wdata = r_xact.wdata;
  assign bus.a_ack     = r_a_ack;
  assign bus.b_ack     = r_b_ack;
  assign bus.a_rdata   = r_a_rdata;
  assign bus.b_rdata   = r_b_rdata;
  assign busy          = r_busy;
  assign last_grant    = r_last_grant;

endmodule

// File: tb/tb_regbus_arbiter.sv
// Scoreboard bench for regbus_arbiter. Expected issues and acks are queued with absolute
// cycle numbers when stimulus is driven, then matched when the DUT produces them.
module tb_regbus_arbiter;

  localparam int unsigned ADDR_W = 6;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned RD_LAT = 2;

  typedef struct {
    bit                port;
    bit                we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    int                issue_cyc;
    int                ack_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic busy;
  logic last_grant;

  exp_t q_iss[$];
  exp_t q_ack[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fails = 0;
  logic [DATA_W-1:0] m_a_rdata = '0;
  logic [DATA_W-1:0] m_b_rdata = '0;
  bit                rd_pend = 1'b0;
  int                rd_cyc = 0;
  logic [DATA_W-1:0] rd_val = '0;

  regbus_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  regbus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus.slave),
    .busy       (busy),
    .last_grant (last_grant)
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] bank(input logic [ADDR_W-1:0] a);
    return 8'h3C ^ DATA_W'(a);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  // Register bank: read data is valid only in the exact cycle RD_LAT after the read strobe.
  always begin
    @(posedge clk);
    #1;
    cyc++;
    bus.reg_rdata = (rd_pend && cyc == rd_cyc) ? rd_val : 8'hEE;
  end

  // Monitor: matches strobes and acks against the scoreboard and checks steady outputs.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      check("busy", 32'(busy),
            32'(q_ack.size() > 0 && cyc >= q_ack[0].issue_cyc && cyc <= q_ack[0].ack_cyc));
      check("strobe_excl", 32'(bus.reg_read & bus.reg_write), 32'(0));
      if (bus.reg_read || bus.reg_write) begin
        if (q_iss.size() == 0) begin
          check("unexp_issue", 32'({bus.reg_read, bus.reg_write}), 32'(0));
        end else begin
          e = q_iss.pop_front();
          check("iss_cyc", 32'(cyc), 32'(e.issue_cyc));
          check("iss_we", 32'(bus.reg_write), 32'(e.we));
          check("iss_addr", 32'(bus.reg_addr), 32'(e.addr));
          if (e.we) check("iss_wdata", 32'(bus.reg_wdata), 32'(e.wdata));
          if (bus.reg_read) begin
            rd_pend = 1'b1;
            rd_cyc  = cyc + int'(RD_LAT);
            rd_val  = bank(bus.reg_addr);
          end
        end
      end
      if (bus.a_ack || bus.b_ack) begin
        if (q_ack.size() == 0) begin
          check("unexp_ack", 32'({bus.a_ack, bus.b_ack}), 32'(0));
        end else begin
          e = q_ack.pop_front();
          check("ack_cyc", 32'(cyc), 32'(e.ack_cyc));
          check("ack_b", 32'(bus.b_ack), 32'(e.port));
          check("ack_a", 32'(bus.a_ack), 32'(!e.port));
          check("last_grant", 32'(last_grant), 32'(e.port));
          if (!e.we && !e.port) m_a_rdata = e.rdata;
          if (!e.we &&  e.port) m_b_rdata = e.rdata;
        end
      end
      check("a_rdata", 32'(bus.a_rdata), 32'(m_a_rdata));
      check("b_rdata", 32'(bus.b_rdata), 32'(m_b_rdata));
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input bit port, input bit req, input bit we,
                       input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata);
    if (port) begin
      bus.b_req = req; bus.b_we = we; bus.b_addr = addr; bus.b_wdata = wdata;
    end else begin
      bus.a_req = req; bus.a_we = we; bus.a_addr = addr; bus.a_wdata = wdata;
    end
  endtask

  task automatic push(input bit port, input bit we, input logic [ADDR_W-1:0] addr,
                      input logic [DATA_W-1:0] wdata, input int issue_cyc, input int ack_cyc);
    exp_t e;
    e.port = port; e.we = we; e.addr = addr; e.wdata = wdata;
    e.rdata = we ? '0 : bank(addr);
    e.issue_cyc = issue_cyc; e.ack_cyc = ack_cyc;
    q_iss.push_back(e);
    q_ack.push_back(e);
  endtask

  // One transaction from an idle arbiter; req drops the cycle after ack.
  task automatic single(input bit port, input bit we, input logic [ADDR_W-1:0] addr,
                        input logic [DATA_W-1:0] wdata);
    int t0;
    int lat;
    t0  = cyc;
    lat = we ? 2 : 2 + int'(RD_LAT);
    drive(port, 1'b1, we, addr, wdata);
    push(port, we, addr, wdata, t0 + 1, t0 + lat);
    repeat (lat + 1) step();
    drive(port, 1'b0, we, addr, wdata);
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    step();
    rst = 1'b0;
    m_a_rdata = '0;
    m_b_rdata = '0;
    step();
  endtask

  task automatic drain(input string tag);
    repeat (4) step();
    check({tag, "_iss_left"}, 32'(q_iss.size()), 32'(0));
    check({tag, "_ack_left"}, 32'(q_ack.size()), 32'(0));
  endtask

  initial begin
    int t0;
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    bus.reg_rdata = 8'hEE;
    repeat (3) step();

    // Reset state
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_last_grant", 32'(last_grant), 32'(1));
    check("rst_strobes", 32'({bus.reg_read, bus.reg_write}), 32'(0));
    check("rst_acks", 32'({bus.a_ack, bus.b_ack}), 32'(0));
    check("rst_addr", 32'(bus.reg_addr), 32'(0));
    check("rst_wdata", 32'(bus.reg_wdata), 32'(0));
    check("rst_rdata", 32'({bus.a_rdata, bus.b_rdata}), 32'(0));
    step();
    rst = 1'b0;
    step();

    // 1: A write alone
    single(1'b0, 1'b1, 6'h05, 8'hA5);
    drain("t1");

    // 2: B read, bank returns 0x3C at address 0
    single(1'b1, 1'b0, 6'h00, 8'h00);
    drain("t2");

    // 3: both held, writes; A,B,A,B after reset
    reset_pulse();
    t0 = cyc;
    drive(1'b0, 1'b1, 1'b1, 6'h10, 8'h11);
    drive(1'b1, 1'b1, 1'b1, 6'h20, 8'h21);
    push(1'b0, 1'b1, 6'h10, 8'h11, t0 + 1,  t0 + 2);
    push(1'b1, 1'b1, 6'h20, 8'h21, t0 + 4,  t0 + 5);
    push(1'b0, 1'b1, 6'h12, 8'h13, t0 + 7,  t0 + 8);
    push(1'b1, 1'b1, 6'h22, 8'h23, t0 + 10, t0 + 11);
    repeat (3) step();
    drive(1'b0, 1'b1, 1'b1, 6'h12, 8'h13);
    repeat (3) step();
    drive(1'b1, 1'b1, 1'b1, 6'h22, 8'h23);
    repeat (6) step();
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    drain("t3");

    // 4: A read to load a_rdata, then reset during the WAIT of a second A read
    single(1'b0, 1'b0, 6'h01, 8'h00);
    drain("t4a");
    t0 = cyc;
    drive(1'b0, 1'b1, 1'b0, 6'h03, 8'h00);
    push(1'b0, 1'b0, 6'h03, 8'h00, t0 + 1, t0 + 2 + int'(RD_LAT));
    repeat (2) step();
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    q_iss.delete();
    q_ack.delete();
    step();
    @(negedge clk);
    check("t4_busy", 32'(busy), 32'(0));
    check("t4_acks", 32'({bus.a_ack, bus.b_ack}), 32'(0));
    check("t4_strobes", 32'({bus.reg_read, bus.reg_write}), 32'(0));
    check("t4_a_rdata", 32'(bus.a_rdata), 32'(0));
    check("t4_last_grant", 32'(last_grant), 32'(1));
    m_a_rdata = '0;
    m_b_rdata = '0;
    step();
    rst = 1'b0;
    step();
    drain("t4b");

    // 5: A held alone for three back-to-back writes
    t0 = cyc;
    drive(1'b0, 1'b1, 1'b1, 6'h30, 8'h01);
    push(1'b0, 1'b1, 6'h30, 8'h01, t0 + 1, t0 + 2);
    push(1'b0, 1'b1, 6'h31, 8'h02, t0 + 4, t0 + 5);
    push(1'b0, 1'b1, 6'h32, 8'h03, t0 + 7, t0 + 8);
    repeat (2) step();
    drive(1'b0, 1'b1, 1'b1, 6'h31, 8'h02);
    repeat (3) step();
    drive(1'b0, 1'b1, 1'b1, 6'h32, 8'h03);
    repeat (4) step();
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    drain("t5");

    // 6: A drops req right after grant and scrambles its inputs; then B reads
    t0 = cyc;
    drive(1'b0, 1'b1, 1'b1, 6'h2A, 8'h5B);
    push(1'b0, 1'b1, 6'h2A, 8'h5B, t0 + 1, t0 + 2);
    step();
    drive(1'b0, 1'b0, 1'b0, 6'h3F, 8'hFF);
    repeat (2) step();
    single(1'b1, 1'b0, 6'h07, 8'h00);
    drain("t6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
